card_shoe_datapath: RTL and testbench
=====================================

CARD_SHOE_DATAPATH -- requirements
Module: card_shoe_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as listed below.
REQ-002 slow_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetb  input  1  asynchronous active-low reset.
REQ-004 load_pcard1, load_pcard2, load_pcard3  input  1 each  player slot load strobes from the game controller.
REQ-005 load_dcard1, load_dcard2, load_dcard3  input  1 each  dealer slot load strobes from the game controller.
REQ-006 new_hand  input  1  single-cycle pulse; clears all card slots for the next hand.
REQ-007 card_in  input  4  external card rank, 1..13 (A..K); used only when CARD_LFSR_EN is undefined.
REQ-008 pcard1, pcard2, pcard3, dcard1, dcard2, dcard3  output  4 each  held rank per slot; 0 = empty.
REQ-009 pscore, dscore  output  4 each  baccarat hand score, 0..9.
REQ-010 cards_dealt  output  6  count of cards accepted since reset, 0..52.
REQ-011 shoe_empty  output  1  high when cards_dealt == 52.
REQ-012 load_err  output  1  sticky error flag.

Function
REQ-013 Source rank SHALL be card_in, or the LFSR rank when CARD_LFSR_EN is defined.
REQ-014 A load SHALL be accepted on a rising edge only if all of the following hold:
- exactly one of the six strobes is high;
- the target slot is 0;
- shoe_empty = 0;
- the source rank is in 1..13;
- new_hand = 0.
REQ-015 An accepted load SHALL write the source rank into the target slot and increment cards_dealt by 1, both on the same edge.
REQ-016 Card value SHALL be derived from rank: 1..9 give 1..9; 10..13 give 0; an empty slot (0) gives 0.
REQ-017 pscore SHALL be registered as (sum of the three player slot values) mod 10; dscore SHALL be the same for the dealer slots.
REQ-018 Each score SHALL update on the same edge as the slot write, so slot and score are both valid after that edge (zero added latency vs. the slot).
REQ-019 The sum SHALL be computed 5 bits wide (max 27) before the mod-10 reduction.
REQ-020 Error cases: when any strobe is high but the load is not accepted, and new_hand = 0, the block SHALL leave slots and count unchanged and set load_err = 1.
REQ-021 load_err SHALL clear only on reset.
REQ-022 new_hand SHALL zero all six slots and both scores on the next edge and SHALL NOT change cards_dealt or load_err.
REQ-023 When new_hand and a strobe are high together, new_hand SHALL win, the load SHALL be dropped, and load_err SHALL NOT be set.
REQ-024 cards_dealt SHALL saturate at 52 (no wrap-around); shoe_empty SHALL be combinational from cards_dealt.
REQ-025 With no strobe and no new_hand, all outputs SHALL hold their values.

Reset
REQ-026 resetb = 0 SHALL immediately (asynchronously) clear:
- all slots, pscore, dscore, cards_dealt and load_err to 0;
- the LFSR to 8'hA5.
REQ-027 A reset asserted mid-hand SHALL discard every card already dealt; the first edge after release SHALL accept a load normally.

Configuration
REQ-028 Macro CARD_LFSR_EN defined:
- an 8-bit LFSR advances every cycle, shifting left with feedback = bit7 ^ bit5 ^ bit4 ^ bit3;
- source rank = (LFSR value mod 13) + 1, always in 1..13;
- card_in is ignored.
REQ-029 Macro CARD_LFSR_EN undefined:
- no LFSR is built;
- source rank = card_in;
- card_in values 0, 14 or 15 are rejected per REQ-020.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Ext mode: card_in=9 on load_pcard1, then card_in=8 on load_pcard2 -> pcard1=9, pcard2=8, pscore=7, cards_dealt=2.
- Ext mode: card_in=13 on load_dcard1, then card_in=5 on load_dcard2, then card_in=4 on load_dcard3 -> dscore=9.
- Ext mode: load_pcard1 and load_dcard1 high together -> no slot change, load_err=1; a second load_pcard1 with pcard1 already filled -> load_err stays 1, pcard1 unchanged.
- Ext mode: deal 52 accepted cards across hands using new_hand pulses -> shoe_empty=1, cards_dealt=52; a further load -> ignored, load_err=1, count stays 52.
- new_hand in the same cycle as load_pcard3 -> all slots 0, cards_dealt unchanged, load_err=0.
- LFSR mode: release reset, assert load_pcard1 on the first edge -> pcard1=10 (0xA5=165; 165 mod 13 = 9; +1 = 10), pscore=0; resetb pulsed low mid-hand -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/card_shoe_datapath.sv
// Baccarat card shoe datapath: six held slots, registered hand scores and a shoe counter.
// Define CARD_LFSR_EN to draw ranks from an internal 8-bit LFSR instead of card_in.
module card_shoe_datapath (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       new_hand,
  input  logic [3:0] card_in,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [5:0] cards_dealt,
  output logic       shoe_empty,
  output logic       load_err
);

  logic [5:0]      stb;
  logic [5:0][3:0] slot_q;
  logic [5:0][3:0] slot_d;
  logic [5:0]      free;
  logic [3:0]      rank;
  logic            one_hot;
  logic            rank_ok;
  logic            accept;
  logic            err_set;
  logic [4:0]      psum;
  logic [4:0]      dsum;

  assign stb = {load_dcard3, load_dcard2, load_dcard1,
                load_pcard3, load_pcard2, load_pcard1};

`ifdef CARD_LFSR_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_mod;
  logic       unused_card;

  assign unused_card = ^card_in;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign lfsr_mod = lfsr % 8'd13;
  assign rank     = lfsr_mod[3:0] + 4'd1;
`else
  assign rank = card_in;
`endif

  function automatic logic [4:0] cval(input logic [3:0] r);
    cval = (r <= 4'd9) ? {1'b0, r} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] m;
    if (s >= 5'd20)      m = s - 5'd20;
    else if (s >= 5'd10) m = s - 5'd10;
    else                 m = s;
    mod10 = m[3:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      free[i] = (slot_q[i] == 4'd0);
    end
  end

  assign one_hot = (stb != 6'd0) && ((stb & (stb - 6'd1)) == 6'd0);
  assign rank_ok = (rank >= 4'd1) && (rank <= 4'd13);
  assign accept  = one_hot && (|(stb & free)) && !shoe_empty
                   && rank_ok && !new_hand;
  assign err_set = (|stb) && !accept && !new_hand;

  always_comb begin
    slot_d = slot_q;
    if (new_hand) begin
      slot_d = '0;
    end else if (accept) begin
      for (int i = 0; i < 6; i++) begin
        if (stb[i]) slot_d[i] = rank;
      end
    end
  end

  // Scores come from the next-state slots so they land on the write edge.
  assign psum = cval(slot_d[0]) + cval(slot_d[1]) + cval(slot_d[2]);
  assign dsum = cval(slot_d[3]) + cval(slot_d[4]) + cval(slot_d[5]);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slot_q      <= '0;
      pscore      <= 4'd0;
      dscore      <= 4'd0;
      cards_dealt <= 6'd0;
      load_err    <= 1'b0;
    end else begin
      slot_q <= slot_d;
      pscore <= mod10(psum);
      dscore <= mod10(dsum);
      if (accept)  cards_dealt <= cards_dealt + 6'd1;
      if (err_set) load_err    <= 1'b1;
    end
  end

  assign shoe_empty = (cards_dealt == 6'd52);

  assign pcard1 = slot_q[0];
  assign pcard2 = slot_q[1];
  assign pcard3 = slot_q[2];
  assign dcard1 = slot_q[3];
  assign dcard2 = slot_q[4];
  assign dcard3 = slot_q[5];

endmodule

// File: tb/tb_card_shoe_datapath.sv
// Scoreboard bench for card_shoe_datapath; expected snapshots are queued per edge.
// Build with CARD_LFSR_EN defined to exercise the LFSR source.
module tb_card_shoe_datapath;

  typedef struct packed {
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] p3;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] ps;
    logic [3:0] ds;
    logic [5:0] cnt;
    logic       empty;
    logic       err;
  } st_t;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [5:0] stb = 6'd0;
  logic       new_hand = 1'b0;
  logic [3:0] card_in = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic [5:0] cards_dealt;
  logic       shoe_empty, load_err;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  st_t   e;
  st_t   exp_q[$];
  int    cyc_q[$];
  string nm_q[$];
  logic [3:0] m [6];

  card_shoe_datapath dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .load_pcard1(stb[0]),
    .load_pcard2(stb[1]),
    .load_pcard3(stb[2]),
    .load_dcard1(stb[3]),
    .load_dcard2(stb[4]),
    .load_dcard3(stb[5]),
    .new_hand   (new_hand),
    .card_in    (card_in),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .cards_dealt(cards_dealt),
    .shoe_empty (shoe_empty),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic st_t actual();
    st_t a;
    a = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
         pscore, dscore, cards_dealt, shoe_empty, load_err};
    return a;
  endfunction

  always @(negedge clk) begin
    if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
      st_t w;
      st_t a;
      string n;
      w = exp_q.pop_front();
      n = nm_q.pop_front();
      void'(cyc_q.pop_front());
      a = actual();
      checks++;
      if (a !== w) begin
        errors++;
        $display("FAIL %s got %h want %h", n, a, w);
      end
    end
  end

  task automatic chk_now(input string nm);
    st_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic step(input logic [5:0] s, input logic nh,
                      input logic [3:0] c, input string nm);
    stb = s;
    new_hand = nh;
    card_in = c;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    stb = 6'd0;
    new_hand = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    resetb = 1'b0;
    #1;
    e = '0;
    for (int i = 0; i < 6; i++) m[i] = 4'd0;
    chk_now(nm);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  function automatic logic [4:0] v(input logic [3:0] r);
    return (r <= 4'd9) ? {1'b0, r} : 5'd0;
  endfunction

  task automatic e_from_m();
    e.p1 = m[0]; e.p2 = m[1]; e.p3 = m[2];
    e.d1 = m[3]; e.d2 = m[4]; e.d3 = m[5];
    e.ps = 4'((v(m[0]) + v(m[1]) + v(m[2])) % 10);
    e.ds = 4'((v(m[3]) + v(m[4]) + v(m[5])) % 10);
  endtask

  initial begin
    int n;
    int slot;
    e = '0;
    do_reset("reset_state");

`ifdef CARD_LFSR_EN
    e.p1 = 4'd10; e.cnt = 6'd1;
    step(6'b000001, 1'b0, 4'd0, "lfsr_first");
    e.p2 = 4'd10; e.cnt = 6'd2;
    step(6'b000010, 1'b0, 4'd0, "lfsr_second");
    e.p3 = 4'd7; e.ps = 4'd7; e.cnt = 6'd3;
    step(6'b000100, 1'b0, 4'd0, "lfsr_third");
    do_reset("lfsr_async_rst");
    e.p1 = 4'd10; e.cnt = 6'd1;
    step(6'b000001, 1'b0, 4'd0, "lfsr_after_rst");
    e.d1 = 4'd10; e.cnt = 6'd2;
    step(6'b001000, 1'b0, 4'd0, "lfsr_dealer");
`else
    e.p1 = 4'd9; e.ps = 4'd9; e.cnt = 6'd1;
    step(6'b000001, 1'b0, 4'd9, "p1_9");
    e.p2 = 4'd8; e.ps = 4'd7; e.cnt = 6'd2;
    step(6'b000010, 1'b0, 4'd8, "p2_8");
    e.d1 = 4'd13; e.ds = 4'd0; e.cnt = 6'd3;
    step(6'b001000, 1'b0, 4'd13, "d1_13");
    e.d2 = 4'd5; e.ds = 4'd5; e.cnt = 6'd4;
    step(6'b010000, 1'b0, 4'd5, "d2_5");
    e.d3 = 4'd4; e.ds = 4'd9; e.cnt = 6'd5;
    step(6'b100000, 1'b0, 4'd4, "d3_4");
    step(6'b000000, 1'b0, 4'd4, "hold");
    e = '0; e.cnt = 6'd5;
    step(6'b000100, 1'b1, 4'd6, "nh_vs_load");
    e.err = 1'b1;
    step(6'b001001, 1'b0, 4'd3, "dual_strobe");
    e.p1 = 4'd2; e.ps = 4'd2; e.cnt = 6'd6;
    step(6'b000001, 1'b0, 4'd2, "p1_after_err");
    step(6'b000001, 1'b0, 4'd7, "p1_filled");
    step(6'b000010, 1'b0, 4'd14, "rank_14");
    do_reset("midhand_rst");
    e.err = 1'b1;
    step(6'b000001, 1'b0, 4'd0, "rank_0");
    do_reset("rst2");
    e.err = 1'b1;
    step(6'b010000, 1'b0, 4'd15, "rank_15");
    do_reset("rst3");
    e.p1 = 4'd12; e.cnt = 6'd1;
    step(6'b000001, 1'b0, 4'd12, "first_after_rst");
    do_reset("rst4");
    for (n = 0; n < 52; n++) begin
      if (n % 6 == 0 && n > 0) begin
        for (int i = 0; i < 6; i++) m[i] = 4'd0;
        e_from_m();
        step(6'b000000, 1'b1, 4'd1, "deal_nh");
      end
      slot = n % 6;
      m[slot] = 4'((n % 13) + 1);
      e_from_m();
      e.cnt = 6'(n + 1);
      e.empty = (n == 51);
      step(6'(1 << slot), 1'b0, m[slot], "deal");
    end
    for (int i = 0; i < 6; i++) m[i] = 4'd0;
    e_from_m();
    step(6'b000000, 1'b1, 4'd1, "nh_full");
    e.err = 1'b1;
    step(6'b000001, 1'b0, 4'd5, "load_empty_shoe");
    step(6'b000000, 1'b1, 4'd5, "nh_keeps_err");
`endif

    for (int k = 0; k < 20 && cyc_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (cyc_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", cyc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
